// File: rtl/alu_acc_fifo.sv
// Clocked ALU with accumulator operand, {C,V,N,Z} flags and a result FIFO driving a tri-state bus.
// Define ALU_SAT_EN to make add/sub saturate unsigned (flags still report the raw carry/borrow/overflow).
module alu_acc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Sel,
    input  logic             UseAcc,
    input  logic             InValid,
    output logic             InReady,
    output logic             OutValid,
    input  logic             OutReady,
    input  logic             En,
    output tri   [WIDTH-1:0] Y,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] Acc
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = WIDTH + 4;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             c_flag;
    logic             v_flag;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;
    logic [WIDTH-1:0] head_res;

    always_comb begin
        op_x   = UseAcc ? acc_q : A;
        sum    = {1'b0, op_x} + {1'b0, B};
        diff   = {1'b0, op_x} - {1'b0, B};
        result = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (Sel)
            3'b000: result = '0;
            3'b001: result = op_x & B;
            3'b010: result = op_x | B;
            3'b011: result = op_x ^ B;
            3'b100: result = ~op_x;
            3'b101: begin
                result = diff[WIDTH-1:0];
                c_flag = diff[WIDTH];
                v_flag = (op_x[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != op_x[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (diff[WIDTH]) result = '0;
`endif
            end
            3'b110: begin
                result = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = (op_x[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != op_x[WIDTH-1]);
`ifdef ALU_SAT_EN
                if (sum[WIDTH]) result = '1;
`endif
            end
            default: result = '1;
        endcase
    end

    // Head fields are masked while empty so Flags reads 0 and an enabled bus reads all zeros.
    always_comb begin
        InReady  = (count_q != FULL_COUNT);
        OutValid = (count_q != '0);
        push     = InValid & InReady;
        pop      = OutValid & OutReady;
        head     = mem_q[rd_ptr_q];
        head_res = OutValid ? head[EW-1:4] : '0;
        Flags    = OutValid ? head[3:0] : 4'b0000;
        Acc      = acc_q;
    end

    assign Y = En ? head_res : 'z;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        acc_d    = acc_q;
        count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = {result, c_flag, v_flag, result[WIDTH-1], (result == '0)};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            acc_d           = result;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            acc_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
        end
    end
endmodule
